bt656_tx: RTL

- ITU-R BT.656 byte-stream transmitter: the sourcing end of the video decoder interface (TD_CLK27/TD_DATA/TD_HS/TD_VS).
- Takes a YCbCr 4:2:2 Avalon-ST pixel stream and emits 8-bit BT.656 with EAV/SAV timing codes, horizontal/vertical blanking and interlaced fields.
- Serves as a loopback/test source for the chroma-key video-in path and as composite-out back end.
- Runs free on the 27 MHz pixel clock; the timing never stalls on input.

---
 rtl/bt656_pkg.sv | 17 +
 rtl/bt656_tx_if.sv | 10 +
 rtl/bt656_timing.sv | 71 +++++++
 rtl/bt656_tx.sv | 103 ++++++++++
 4 files changed

// File: rtl/bt656_pkg.sv
// Shared constants, types and the timing-reference code helper for the BT.656 transmitter.
package bt656_pkg;

   localparam logic [7:0] TRS_FF  = 8'hFF;
   localparam logic [7:0] TRS_00  = 8'h00;
   localparam logic [7:0] BLANK_C = 8'h80;
   localparam logic [7:0] BLANK_Y = 8'h10;

   typedef enum logic [1:0] {POS_EAV, POS_HBLANK, POS_SAV, POS_ACTIVE} pos_t;
   typedef enum logic {UNLOCKED, LOCKED} lock_t;

   // Fourth byte of a timing reference: 1,F,V,H plus protection bits.
   function automatic logic [7:0] xy_code(input logic f, input logic v, input logic h);
      return {1'b1, f, v, h, v ^ h, f ^ h, f ^ v, f ^ v ^ h};
   endfunction

endpackage

// File: rtl/bt656_tx_if.sv
// Avalon-ST 4:2:2 pixel sink: {Y, C} words with start-of-frame marker.
interface bt656_tx_if;
   logic [15:0] sink_data;
   logic        sink_valid;
   logic        sink_startofpacket;
   logic        sink_ready;

   modport master (output sink_data, sink_valid, sink_startofpacket, input sink_ready);
   modport slave  (input sink_data, sink_valid, sink_startofpacket, output sink_ready);
endinterface

// File: rtl/bt656_timing.sv
// Free-running h/line counters and the per-position decode of the BT.656 raster.
module bt656_timing
   import bt656_pkg::*;
#(
   parameter int unsigned H_ACTIVE    = 720,
   parameter int unsigned H_TOTAL     = 1716,
   parameter int unsigned LINES_TOTAL = 525,
   parameter int unsigned F1_START    = 263,
   parameter int unsigned V_BLANK     = 22,
   parameter int unsigned V_ACTIVE    = 240,
   parameter int unsigned HS_WIDTH    = 64,
   parameter int unsigned VS_LINES    = 3
) (
   input  logic       clk,
   input  logic       reset,
   output logic       field,
   output logic       vblank,
   output pos_t       region,
   output logic       phase,
   output logic [1:0] trs_idx,
   output logic       first_px,
   output logic       hs,
   output logic       vs
);
   localparam int unsigned HW        = $clog2(H_TOTAL);
   localparam int unsigned LW        = $clog2(LINES_TOTAL);
   localparam int unsigned SAV_START = H_TOTAL - 2 * H_ACTIVE - 4;
   localparam int unsigned ACT_START = SAV_START + 4;
   localparam logic        ACT_ODD   = 1'(ACT_START % 2);

   logic [HW-1:0] h;
   logic [LW-1:0] line;
   logic [LW-1:0] fline;

   // Byte and line counters; both restart from the EAV of line 0 on reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         h    <= '0;
         line <= '0;
      end else if (h == HW'(H_TOTAL - 1)) begin
         h    <= '0;
         line <= (line == LW'(LINES_TOTAL - 1)) ? '0 : line + 1'b1;
      end else begin
         h <= h + 1'b1;
      end
   end

   // Decode field, vertical blanking, horizontal region and byte phase.
   always_comb begin
      field    = (line >= LW'(F1_START));
      fline    = field ? line - LW'(F1_START) : line;
      vblank   = !((fline >= LW'(V_BLANK)) && (fline < LW'(V_BLANK + V_ACTIVE)));
      hs       = (h < HW'(HS_WIDTH));
      vs       = (fline < LW'(VS_LINES));
      region   = POS_ACTIVE;
      trs_idx  = 2'd0;
      phase    = h[0] ^ ACT_ODD;
      if (h < HW'(4)) begin
         region  = POS_EAV;
         trs_idx = h[1:0];
      end else if (h < HW'(SAV_START)) begin
         region = POS_HBLANK;
         phase  = h[0];
      end else if (h < HW'(ACT_START)) begin
         region  = POS_SAV;
         trs_idx = 2'(h - HW'(SAV_START));
      end
      first_px = (region == POS_ACTIVE) && (h == HW'(ACT_START)) && (line == LW'(V_BLANK));
   end

endmodule

// File: rtl/bt656_tx.sv
// BT.656 byte-stream transmitter: raster timing, input lock tracking and output byte mux.
module bt656_tx
   import bt656_pkg::*;
#(
   parameter int unsigned H_ACTIVE    = 720,
   parameter int unsigned H_TOTAL     = 1716,
   parameter int unsigned LINES_TOTAL = 525,
   parameter int unsigned F1_START    = 263,
   parameter int unsigned V_BLANK     = 22,
   parameter int unsigned V_ACTIVE    = 240,
   parameter int unsigned HS_WIDTH    = 64,
   parameter int unsigned VS_LINES    = 3
) (
   input  logic             clk,
   input  logic             reset,
   bt656_tx_if.slave        sink,
   output logic [7:0]       td_data,
   output logic             td_hs,
   output logic             td_vs,
   output logic             locked,
   output logic             underflow,
   input  logic             clear_flags
);
   logic       field, vblank, phase, first_px, hs, vs;
   logic [1:0] trs_idx;
   pos_t       region;
   lock_t      state;
   logic [7:0] y_latch;
   logic [7:0] nxt_data;
   logic       c_cyc, accept;

   bt656_timing #(
      .H_ACTIVE(H_ACTIVE), .H_TOTAL(H_TOTAL), .LINES_TOTAL(LINES_TOTAL),
      .F1_START(F1_START), .V_BLANK(V_BLANK), .V_ACTIVE(V_ACTIVE),
      .HS_WIDTH(HS_WIDTH), .VS_LINES(VS_LINES)
   ) u_timing (
      .clk(clk), .reset(reset), .field(field), .vblank(vblank), .region(region),
      .phase(phase), .trs_idx(trs_idx), .first_px(first_px), .hs(hs), .vs(vs)
   );

   assign locked = (state == LOCKED);

   // Word acceptance: in-stream words while locked, only the frame-first SOP while unlocked.
   always_comb begin
      c_cyc = (region == POS_ACTIVE) && !vblank && !phase;
      if (state == LOCKED)
         accept = c_cyc && sink.sink_valid && !(sink.sink_startofpacket && !first_px);
      else
         accept = c_cyc && sink.sink_valid && sink.sink_startofpacket && first_px;
      sink.sink_ready = !reset && (accept ||
                        ((state == UNLOCKED) && sink.sink_valid && !sink.sink_startofpacket));
   end

   // Next output byte for the current raster position.
   always_comb begin
      nxt_data = BLANK_C;
      case (region)
         POS_EAV, POS_SAV: begin
            case (trs_idx)
               2'd0:    nxt_data = TRS_FF;
               2'd3:    nxt_data = xy_code(field, vblank, region == POS_EAV);
               default: nxt_data = TRS_00;
            endcase
         end
         POS_HBLANK: nxt_data = phase ? BLANK_Y : BLANK_C;
         default: begin
            if (vblank)
               nxt_data = phase ? BLANK_Y : BLANK_C;
            else if (!phase)
               nxt_data = accept ? sink.sink_data[7:0] : BLANK_C;
            else
               nxt_data = (state == LOCKED) ? y_latch : BLANK_Y;
         end
      endcase
   end

   // Lock FSM, Y latch, sticky underflow and registered video outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= UNLOCKED;
         underflow <= 1'b0;
         y_latch   <= BLANK_Y;
         td_data   <= BLANK_C;
         td_hs     <= 1'b0;
         td_vs     <= 1'b0;
      end else begin
         td_data <= nxt_data;
         td_hs   <= hs;
         td_vs   <= vs;
         if (accept)
            y_latch <= sink.sink_data[15:8];
         case (state)
            LOCKED:   if (c_cyc && !accept) state <= UNLOCKED;
            default:  if (accept) state <= LOCKED;
         endcase
         if ((state == LOCKED) && c_cyc && !sink.sink_valid)
            underflow <= 1'b1;
         else if (clear_flags)
            underflow <= 1'b0;
      end
   end

endmodule
